debounce_scheduler: RTL and testbench

//  Time-multiplexed debounce engine for N push-buttons: one shared saturating integrator
//  is scheduled round-robin across all channels once per sample tick.

---
 rtl/debounce_scheduler_if.sv | 12 +
 rtl/debounce_scheduler.sv | 110 +++++++++++
 tb/tb_debounce_scheduler.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/debounce_scheduler_if.sv
// debounce_scheduler_if: raw button inputs and debounced level/event outputs of the scheduler.
interface debounce_scheduler_if #(parameter int N_BTN = 4);
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] db_state;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] long_press;
    logic             scan_busy;
    logic             overrun;
    modport master (output btn, input db_state, press_pulse, release_pulse, long_press, scan_busy, overrun);
    modport slave  (input btn, output db_state, press_pulse, release_pulse, long_press, scan_busy, overrun);
endinterface

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: round-robin shared-integrator debouncer for N buttons.
// Define DEBOUNCE_SCHED_LONGPRESS_EN to add per-channel long-press detection.
module debounce_scheduler #(
    parameter int N_BTN      = 4,
    parameter int TICK_DIV   = 1000,
    parameter int THRESHOLD  = 20,
    parameter int LONG_TICKS = 500
) (
    input logic                 clk,
    input logic                 rst_n,
    debounce_scheduler_if.slave bus
);
    localparam int CW = $clog2(THRESHOLD + 1);
    localparam int TW = $clog2(TICK_DIV);
    localparam int IW = N_BTN > 1 ? $clog2(N_BTN) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q;
    logic [TW-1:0]    tick_cnt_q;
    logic [IW-1:0]    idx_q;
    logic [N_BTN-1:0] s1_q, s2_q, db_q, press_q, rel_q;
    logic [CW-1:0]    cnt_q [N_BTN];
    logic             busy_q, ovr_q;
    logic             tick, cur, db_d;
    logic [CW-1:0]    cnt_d;

    assign tick = tick_cnt_q == TW'(TICK_DIV - 1);
    assign cur  = s2_q[idx_q];
    // Saturating integrator for the channel owning the current slot.
    assign cnt_d = cur ? (cnt_q[idx_q] < CW'(THRESHOLD) ? cnt_q[idx_q] + CW'(1) : cnt_q[idx_q])
                       : (cnt_q[idx_q] != '0 ? cnt_q[idx_q] - CW'(1) : cnt_q[idx_q]);
    assign db_d  = cnt_d == CW'(THRESHOLD) ? 1'b1 : cnt_d == '0 ? 1'b0 : db_q[idx_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            idx_q      <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            db_q       <= '0;
            press_q    <= '0;
            rel_q      <= '0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
        end else begin
            s1_q       <= bus.btn;
            s2_q       <= s1_q;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
            press_q    <= '0;
            rel_q      <= '0;
            if (tick && state_q == SCAN) ovr_q <= 1'b1;
            if (state_q == IDLE) begin
                if (tick) begin
                    state_q <= SCAN;
                    busy_q  <= 1'b1;
                    idx_q   <= '0;
                end
            end else begin
                cnt_q[idx_q]   <= cnt_d;
                db_q[idx_q]    <= db_d;
                press_q[idx_q] <= db_d & ~db_q[idx_q];
                rel_q[idx_q]   <= ~db_d & db_q[idx_q];
                if (idx_q == IW'(N_BTN - 1)) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    idx_q <= idx_q + IW'(1);
                end
            end
        end
    end

`ifdef DEBOUNCE_SCHED_LONGPRESS_EN
    localparam int HW = $clog2(LONG_TICKS + 1);

    logic [HW-1:0]    hold_q [N_BTN];
    logic [N_BTN-1:0] lp_q;
    logic [HW-1:0]    hold_d;

    // Hold time follows the freshly updated debounced level of the slot channel.
    assign hold_d = !db_d ? '0
                  : hold_q[idx_q] < HW'(LONG_TICKS) ? hold_q[idx_q] + HW'(1) : hold_q[idx_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_q <= '0;
            for (int i = 0; i < N_BTN; i++) hold_q[i] <= '0;
        end else begin
            lp_q <= '0;
            if (state_q == SCAN) begin
                hold_q[idx_q] <= hold_d;
                lp_q[idx_q]   <= hold_d == HW'(LONG_TICKS) && hold_q[idx_q] != HW'(LONG_TICKS);
            end
        end
    end

    assign bus.long_press = lp_q;
`else
    assign bus.long_press = '0;
`endif

    assign bus.db_state      = db_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = rel_q;
    assign bus.scan_busy     = busy_q;
    assign bus.overrun       = ovr_q;
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: scoreboard bench; a slot-level model predicts every pulse cycle.
`timescale 1ns/1ps
module tb_debounce_scheduler;
    localparam int N = 4, TD = 8, TH = 3, LT = 5;

    typedef struct {
        int           cyc;
        logic [N-1:0] p, r, l;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    debounce_scheduler_if #(.N_BTN(N)) bus ();
    debounce_scheduler_if #(.N_BTN(N)) bus2 ();

    debounce_scheduler #(.N_BTN(N), .TICK_DIV(TD), .THRESHOLD(TH), .LONG_TICKS(LT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    debounce_scheduler #(.N_BTN(N), .TICK_DIV(3), .THRESHOLD(TH), .LONG_TICKS(LT)) dut_ovr (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    int checks = 0, failures = 0;
    ev_t q[$];
    int cyc = 0;
    logic [N-1:0] ms1, ms2, mdb;
    int mcnt[N], mhold[N];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Reference: channel ch is sampled once per tick, in the edge where cyc%TD == ch+1,
    // using the button level seen two edges earlier.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            cyc = 0; ms1 = '0; ms2 = '0; mdb = '0;
            mcnt = '{default:0}; mhold = '{default:0};
            q.delete();
        end else begin
            ev_t e;
            int ch;
            cyc++;
            ch = cyc % TD - 1;
            e = '{cyc, '0, '0, '0};
            if (cyc >= TD + 1 && ch >= 0 && ch < N) begin
                if (ms2[ch]) begin
                    if (mcnt[ch] < TH) mcnt[ch]++;
                end else if (mcnt[ch] > 0) mcnt[ch]--;
                if (mcnt[ch] == TH && !mdb[ch]) begin mdb[ch] = 1'b1; e.p[ch] = 1'b1; end
                if (mcnt[ch] == 0 && mdb[ch]) begin mdb[ch] = 1'b0; e.r[ch] = 1'b1; end
`ifdef DEBOUNCE_SCHED_LONGPRESS_EN
                if (!mdb[ch]) mhold[ch] = 0;
                else if (mhold[ch] < LT) begin
                    mhold[ch]++;
                    if (mhold[ch] == LT) e.l[ch] = 1'b1;
                end
`endif
            end
            if ((e.p | e.r | e.l) != '0) q.push_back(e);
            ms2 = ms1;
            ms1 = bus.btn;
        end
    end

    initial forever begin
        logic [3*N-1:0] obs, exp;
        ev_t e;
        @(negedge clk);
        if (rst_n) begin
            obs = {bus.press_pulse, bus.release_pulse, bus.long_press};
            exp = '0;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                exp = {e.p, e.r, e.l};
            end
            if (obs != '0 || exp != '0) begin
                check($sformatf("pulses@%0d", cyc), 32'(obs), 32'(exp));
                check($sformatf("db_state@%0d", cyc), 32'(bus.db_state), 32'(mdb));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        bus.btn = '1;
        bus2.btn = '0;
        repeat (3) @(negedge clk);
        check("rst_db", 32'(bus.db_state), 0);
        check("rst_pulses", 32'({bus.press_pulse, bus.release_pulse, bus.long_press}), 0);
        check("rst_busy", 32'(bus.scan_busy), 0);
        check("rst_ovr", 32'(bus.overrun), 0);
        bus.btn = '0;
        #1 rst_n = 1'b1;
        wait_cyc(5);
        check("ovr2_before", 32'(bus2.overrun), 0);
        wait_cyc(6);
        check("ovr2_set", 32'(bus2.overrun), 1);
        wait_cyc(7);
        check("busy_pre_tick", 32'(bus.scan_busy), 0);
        wait_cyc(8);
        check("busy_scan_start", 32'(bus.scan_busy), 1);
        wait_cyc(11);
        check("busy_last_slot", 32'(bus.scan_busy), 1);
        wait_cyc(12);
        check("busy_scan_end", 32'(bus.scan_busy), 0);
        wait_cyc(100);
        check("idle_db", 32'(bus.db_state), 0);
        check("idle_ovr", 32'(bus.overrun), 0);

        bus.btn = 4'h1;
        repeat (6 * TD) @(negedge clk);
        check("press0_db", 32'(bus.db_state), 1);
        bus.btn = 4'h0;
        repeat (6 * TD) @(negedge clk);
        check("release0_db", 32'(bus.db_state), 0);

        for (int i = 0; i < 20; i++) begin
            bus.btn[1] = ~bus.btn[1];
            repeat (TD) @(negedge clk);
        end
        bus.btn = 4'h0;
        repeat (6 * TD) @(negedge clk);
        check("bounce1_db", 32'(bus.db_state), 0);

        bus.btn = 4'hF;
        repeat (6 * TD) @(negedge clk);
        check("all_db", 32'(bus.db_state), 4'hF);
        bus.btn = 4'h0;
        repeat (6 * TD) @(negedge clk);
        check("all_release_db", 32'(bus.db_state), 0);
        check("ovr2_sticky", 32'(bus2.overrun), 1);

        bus.btn = 4'h4;
        for (int k = 0; k < 200 && mcnt[2] != 2; k++) @(negedge clk);
        check("cnt2_reach_bound", 32'(mcnt[2]), 2);
        while (cyc % TD != 2) @(negedge clk);
        check("midscan_busy", 32'(bus.scan_busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.scan_busy), 0);
        check("midrst_db", 32'(bus.db_state), 0);
        check("midrst_ovr2", 32'(bus2.overrun), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(7);
        check("rst2_busy_pre", 32'(bus.scan_busy), 0);
        wait_cyc(8);
        check("rst2_busy_start", 32'(bus.scan_busy), 1);
        repeat (6 * TD) @(negedge clk);
        check("press2_db", 32'(bus.db_state), 4'h4);
        bus.btn = 4'h8;
        repeat (8 * TD) @(negedge clk);
        check("hold3_db", 32'(bus.db_state), 4'h8);
        bus.btn = 4'h0;
        repeat (6 * TD) @(negedge clk);
        check("final_db", 32'(bus.db_state), 0);
        check("final_ovr", 32'(bus.overrun), 0);
        check("queue_drained", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
